// File: rtl/mem_burst_ctrl.sv
// Single-port synchronous memory with valid/ready beat handshake, byte strobes,
// incrementing wrap-around bursts, a fixed-latency read pipeline and range errors.
module mem_burst_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 48,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  err,
    output logic                  last,
    output logic                  busy
);

    localparam int unsigned NumBytes = WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
    // Pipeline holds only the final read beat, sitting in the output stage.
    localparam logic [RD_LAT-1:0]     PipeTail = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    state_e                state_q, state_d;
    logic                  alive_q;
    logic                  wr_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic                  err_q, last_q;
    logic [RD_LAT-1:0]     pv_q;
    logic [WIDTH-1:0]      pd_q [RD_LAT];

    logic [WIDTH-1:0]      mem [0:DEPTH-1];

    logic                  accept, beat_wr, final_beat, in_range;
    logic [ADDR_WIDTH-1:0] beat_addr, next_addr;
    logic [WIDTH-1:0]      rd_word;

    assign accept = valid && ready;

    always_comb begin
        beat_addr  = (state_q == StIdle) ? addr : cur_addr_q;
        beat_wr    = (state_q == StIdle) ? wr_rd : wr_q;
        final_beat = (state_q == StIdle) ? (len == '0) : (cnt_q == LEN_WIDTH'(1));
        in_range   = {1'b0, beat_addr} < DepthExt;
        next_addr  = (beat_addr == LastAddr) ? '0 : beat_addr + 1'b1;
        rd_word    = in_range ? mem[beat_addr] : '0;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = final_beat ? (beat_wr ? StIdle : StDrain) : StBurst;
            StBurst: if (accept && final_beat) state_d = beat_wr ? StIdle : StDrain;
            StDrain: if (pv_q == PipeTail) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready = alive_q && (state_q != StDrain);
        busy  = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            alive_q    <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            cur_addr_q <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            pv_q       <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) pd_q[k] <= '0;
        end else begin
            alive_q <= 1'b1;
            if (accept) begin
                if (state_q == StIdle) wr_q <= wr_rd;
                cnt_q      <= (state_q == StIdle) ? len : cnt_q - 1'b1;
                cur_addr_q <= next_addr;
            end
            err_q   <= accept && !in_range;
            last_q  <= accept && final_beat;
            pv_q[0] <= accept && !beat_wr;
            if (accept && !beat_wr) pd_q[0] <= rd_word;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                if (pv_q[k-1]) pd_q[k] <= pd_q[k-1];
            end
        end
    end

    // Storage is deliberately not reset so contents survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (accept && beat_wr && in_range) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (wstrb[b]) mem[beat_addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rvalid = pv_q[RD_LAT-1];
    assign rdata  = pd_q[RD_LAT-1];
    assign err    = err_q;
    assign last   = last_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: directed scenarios plus randomized bursts scored
// against an array/queue model of the memory and its event timing.
module tb_mem_burst_ctrl;

    localparam int W   = 32;
    localparam int D   = 48;
    localparam int AW  = 6;
    localparam int LW  = 4;
    localparam int LAT = 2;

    logic          clk   = 1'b0;
    logic          res   = 1'b1;
    logic          valid = 1'b0;
    logic          wr_rd = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [LW-1:0] len   = '0;
    logic [W-1:0]  wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          ready, rvalid, err, last, busy;
    logic [W-1:0]  rdata;

    mem_burst_ctrl #(
        .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .res(res), .valid(valid), .ready(ready), .wr_rd(wr_rd), .addr(addr),
        .len(len), .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .rvalid(rvalid),
        .err(err), .last(last), .busy(busy)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; an event "in cycle c" is seen at the
    // falling edge following rising edge c.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; logic [W-1:0] d;} rv_t;
    rv_t obs_rv[$], exp_rv[$];
    int  obs_err[$], exp_err[$], obs_last[$], exp_last[$];
    rv_t mon_e;

    always @(negedge clk) begin
        if (!res) begin
            if (rvalid) begin
                mon_e.c = cyc; mon_e.d = rdata; obs_rv.push_back(mon_e);
            end
            if (err)  obs_err.push_back(cyc);
            if (last) obs_last.push_back(cyc);
        end
    end

    logic [W-1:0] mdl [D];
    logic [W-1:0] wd  [16];
    logic [3:0]   ws  [16];
    int checks = 0;
    int errors = 0;

    function automatic int step_addr(input int a);
        return (a == D - 1) ? 0 : (a + 1) % 64;
    endfunction

    task automatic clear_q();
        obs_rv.delete(); exp_rv.delete(); obs_err.delete();
        exp_err.delete(); obs_last.delete(); exp_last.delete();
    endtask

    // Drives one burst from a falling edge; stops before beat stop_after if >= 0.
    task automatic run_burst(input bit wr, input int start, input int ln, input int gap_at,
                             input int gap_n, input int stop_after,
                             output int first_acc, output int last_acc);
        int a, t, acc;
        rv_t e;
        a = start; first_acc = -1; last_acc = -1;
        for (int i = 0; i <= ln; i++) begin
            if (i == stop_after) begin valid = 1'b0; return; end
            if (i == gap_at && gap_n > 0) begin
                valid = 1'b0;
                repeat (gap_n) @(negedge clk);
            end
            valid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            if (i == 0) begin
                wr_rd = wr; addr = AW'(start); len = LW'(ln);
            end else begin
                wr_rd = 1'($urandom); addr = AW'($urandom); len = LW'($urandom);
            end
            t = 0;
            while (!ready && t < 100) begin @(negedge clk); t++; end
            if (t == 100) begin
                checks++; errors++;
                $display("FAIL ready_timeout beat %0d got ready=0 want 1", i);
                valid = 1'b0;
                return;
            end
            acc = cyc + 1;
            if (i == 0) first_acc = acc;
            last_acc = acc;
            if (wr) begin
                if (a < D) for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[a][8*b +: 8] = wd[i][8*b +: 8];
            end else begin
                e.c = acc + LAT - 1; e.d = (a < D) ? mdl[a] : '0; exp_rv.push_back(e);
            end
            if (a >= D) exp_err.push_back(acc);
            if (i == ln) exp_last.push_back(acc);
            @(negedge clk);
            a = step_addr(a);
        end
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || !ready) && t < 100) begin @(negedge clk); t++; end
        if (t == 100) begin
            checks++; errors++;
            $display("FAIL idle_timeout got busy=%b ready=%b want 0/1", busy, ready);
        end
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", last); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
        for (int i = 0; i < D; i++) begin mdl[i] = $urandom; dut.mem[i] = mdl[i]; end
        #1 res = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got %b want 0", ready); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b want 1", ready); end
    endtask

    task automatic test_single_beat();
        int f, l;
        clear_q();
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        run_burst(1'b1, 5, 0, -1, 0, -1, f, l); wait_idle();
        run_burst(1'b0, 5, 0, -1, 0, -1, f, l); wait_idle();
        checks++;
        if (obs_rv.size() != 1) begin
            errors++; $display("FAIL single_rv_count got %0d want 1", obs_rv.size());
        end else begin
            checks++; if (obs_rv[0].d !== 32'hDEADBEEF) begin
                errors++; $display("FAIL single_rdata got %h want deadbeef", obs_rv[0].d); end
            checks++; if (obs_rv[0].c != f + 1) begin
                errors++; $display("FAIL single_latency got %0d want %0d", obs_rv[0].c, f + 1); end
        end
        checks++; if (obs_last.size() != 2) begin
            errors++; $display("FAIL single_last_count got %0d want 2", obs_last.size()); end
        checks++; if (obs_err.size() != 0) begin
            errors++; $display("FAIL single_err_count got %0d want 0", obs_err.size()); end
    endtask

    task automatic test_byte_strobe();
        int f, l;
        clear_q();
        dut.mem[3] = 32'h11223344; mdl[3] = 32'h11223344;
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        run_burst(1'b1, 3, 0, -1, 0, -1, f, l); wait_idle();
        run_burst(1'b0, 3, 0, -1, 0, -1, f, l); wait_idle();
        // strobe bits 0 and 2 replace bytes 0 and 2 only
        checks++; if (dut.mem[3] !== 32'h11BB33DD) begin
            errors++; $display("FAIL strb_mem got %h want 11bb33dd", dut.mem[3]); end
        checks++;
        if (obs_rv.size() != 1 || obs_rv[0].d !== 32'h11BB33DD) begin
            errors++; $display("FAIL strb_read got n=%0d d=%h want n=1 d=11bb33dd",
                               obs_rv.size(), obs_rv.size() > 0 ? obs_rv[0].d : 'x);
        end
    endtask

    task automatic test_wrap_burst();
        int f, l;
        int wa[4] = '{46, 47, 0, 1};
        clear_q();
        for (int i = 0; i < 4; i++) begin wd[i] = W'(i + 1); ws[i] = 4'hF; end
        run_burst(1'b1, 46, 3, -1, 0, -1, f, l); wait_idle();
        for (int k = 0; k < 4; k++) begin
            checks++; if (dut.mem[wa[k]] !== W'(k + 1)) begin
                errors++; $display("FAIL wrap_mem[%0d] got %h want %h", wa[k], dut.mem[wa[k]], k + 1); end
        end
        run_burst(1'b0, 46, 3, -1, 0, -1, f, l);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL wrap_drain%0d got ready=%b busy=%b want 0/1", k, ready, busy); end
            @(negedge clk);
        end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL wrap_drain_exit got ready=%b busy=%b want 1/0", ready, busy); end
        wait_idle();
        checks++;
        if (obs_rv.size() != 4) begin
            errors++; $display("FAIL wrap_rv_count got %0d want 4", obs_rv.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (obs_rv[k].d !== W'(k + 1) || obs_rv[k].c != f + LAT - 1 + k) begin
                    errors++; $display("FAIL wrap_rv%0d got d=%h c=%0d want d=%h c=%0d", k,
                                       obs_rv[k].d, obs_rv[k].c, k + 1, f + LAT - 1 + k);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        int f1, f2, l, bad;
        logic [W-1:0] snap [D];
        clear_q();
        for (int i = 0; i < D; i++) snap[i] = mdl[i];
        wd[0] = $urandom; ws[0] = 4'hF;
        run_burst(1'b1, 50, 0, -1, 0, -1, f1, l); wait_idle();
        run_burst(1'b0, 50, 0, -1, 0, -1, f2, l); wait_idle();
        checks++;
        if (obs_err.size() != 2 || obs_err[0] != f1 || obs_err[1] != f2) begin
            errors++; $display("FAIL oor_err got n=%0d want 2 pulses at %0d,%0d", obs_err.size(), f1, f2);
        end
        checks++;
        if (obs_rv.size() != 1 || obs_rv[0].d !== '0) begin
            errors++; $display("FAIL oor_read got n=%0d want 1 beat with rdata 0", obs_rv.size());
        end
        bad = 0;
        for (int i = 0; i < D; i++) if (dut.mem[i] !== snap[i]) bad++;
        checks++; if (bad != 0) begin
            errors++; $display("FAIL oor_mem got %0d changed words want 0", bad); end
    endtask

    task automatic test_gapped_reset();
        int f, l, rc, n;
        logic [W-1:0] wsave [8];
        clear_q();
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; wsave[i] = wd[i]; end
        run_burst(1'b1, 8, 7, 2, 2, -1, f, l); wait_idle();
        for (int i = 0; i < 8; i++) begin
            checks++; if (dut.mem[8+i] !== wsave[i]) begin
                errors++; $display("FAIL gap_mem[%0d] got %h want %h", 8 + i, dut.mem[8+i], wsave[i]); end
        end
        checks++; if (obs_last.size() != 1 || obs_last[0] != l) begin
            errors++; $display("FAIL gap_last got n=%0d want 1 at %0d", obs_last.size(), l); end
        clear_q();
        run_burst(1'b0, 8, 7, -1, 0, 3, f, l);
        #1 res = 1'b1;
        rc = cyc;
        #1;
        checks++; if (rvalid !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL midrst_out got rv=%b busy=%b ready=%b want 0/0/0", rvalid, busy, ready);
        end
        repeat (3) @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rv got %b want 0", rvalid); end
        #1 res = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready); end
        n = 0;
        foreach (exp_rv[k]) if (exp_rv[k].c <= rc) n++;
        checks++;
        if (obs_rv.size() != n) begin
            errors++; $display("FAIL midrst_rv_count got %0d want %0d", obs_rv.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                checks++; if (obs_rv[k].d !== exp_rv[k].d) begin
                    errors++; $display("FAIL midrst_rv%0d got %h want %h", k, obs_rv[k].d, exp_rv[k].d); end
            end
        end
        for (int i = 8; i < 16; i++) begin
            checks++; if (dut.mem[i] !== mdl[i]) begin
                errors++; $display("FAIL retain_mem[%0d] got %h want %h", i, dut.mem[i], mdl[i]); end
        end
    endtask

    task automatic test_random();
        int f, l, ln, bad;
        clear_q();
        for (int n = 0; n < 40; n++) begin
            ln = $urandom_range(0, 5);
            for (int i = 0; i <= ln; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            run_burst(1'($urandom), $urandom_range(0, 63), ln, $urandom_range(1, 6),
                      $urandom_range(0, 2), -1, f, l);
        end
        wait_idle();
        checks++;
        if (obs_rv.size() != exp_rv.size()) begin
            errors++; $display("FAIL rnd_rv_count got %0d want %0d", obs_rv.size(), exp_rv.size());
        end else begin
            foreach (exp_rv[k]) begin
                checks++; if (obs_rv[k].d !== exp_rv[k].d || obs_rv[k].c != exp_rv[k].c) begin
                    errors++; $display("FAIL rnd_rv%0d got d=%h c=%0d want d=%h c=%0d", k,
                                       obs_rv[k].d, obs_rv[k].c, exp_rv[k].d, exp_rv[k].c);
                end
            end
        end
        checks++; if (obs_err != exp_err) begin
            errors++; $display("FAIL rnd_err got n=%0d want n=%0d", obs_err.size(), exp_err.size()); end
        checks++; if (obs_last != exp_last) begin
            errors++; $display("FAIL rnd_last got n=%0d want n=%0d", obs_last.size(), exp_last.size()); end
        bad = 0;
        for (int i = 0; i < D; i++) if (dut.mem[i] !== mdl[i]) bad++;
        checks++; if (bad != 0) begin
            errors++; $display("FAIL rnd_mem got %0d differing words want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_byte_strobe();
        test_wrap_burst();
        test_out_of_range();
        test_gapped_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
